// File: rtl/axi_mem_port_arbiter.sv
// axi_mem_port_arbiter
// Shares one single-port synchronous SRAM between a write requester and a
// read requester. Grants at most one word operation per cycle using sticky
// round-robin with a bounded run length. The SRAM command is registered, and
// read data comes back on rd_valid two cycles after rd_gnt.
//
// Optional feature: define AXI_MEM_ARB_PERF_EN to build the three saturating
// performance counters. When it is not defined, perf_* outputs are tied to 0.
// The port list is the same in both builds.
//
// Arbitration state (owner_q):
//   state  | meaning
//   OWN_WR | write port holds the sticky grant; run_q counts its consecutive grants
//   OWN_RD | read port holds the sticky grant; run_q counts its consecutive grants
//
// MAX_RUN must be in the range 1..15 because run_q is only 4 bits wide.

module axi_mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_RUN    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_conf_cnt
);

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);

  owner_t     owner_q, owner_d;
  logic [3:0] run_q, run_d;
  logic       grant_wr, grant_rd;
  logic       owner_granted;

  // Arbitration state register: owner and run length.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      owner_q <= OWN_WR;
      run_q   <= '0;
    end else begin
      owner_q <= owner_d;
      run_q   <= run_d;
    end
  end

  // Grant selection and next owner/run. Grants are suppressed while in reset.
  always_comb begin
    grant_wr      = 1'b0;
    grant_rd      = 1'b0;
    owner_granted = 1'b0;
    owner_d       = owner_q;
    run_d         = run_q;
    if (ARESETn) begin
      if (wr_req && rd_req) begin
        // Owner keeps the grant until it has used up its run; then the other side gets it.
        if (run_q < RUN_MAX) begin
          grant_wr = (owner_q == OWN_WR);
          grant_rd = (owner_q == OWN_RD);
        end else begin
          grant_wr = (owner_q == OWN_RD);
          grant_rd = (owner_q == OWN_WR);
        end
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end

      owner_granted = (grant_wr && owner_q == OWN_WR) || (grant_rd && owner_q == OWN_RD);

      if (!wr_req && !rd_req) begin
        run_d = '0;
      end else if (owner_granted) begin
        run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
      end else begin
        owner_d = grant_wr ? OWN_WR : OWN_RD;
        run_d   = 4'd1;
      end
    end
  end

  assign wr_gnt = grant_wr;
  assign rd_gnt = grant_rd;

  // Registered SRAM command. Address and write data hold when idle; the strobe
  // is cleared on anything other than a write so a read can never modify memory.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_en <= grant_wr | grant_rd;
      mem_we <= grant_wr;
      if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_wstrb <= wr_strb;
      end else if (grant_rd) begin
        mem_addr  <= rd_addr;
        mem_wstrb <= '0;
      end else begin
        mem_wstrb <= '0;
      end
    end
  end

  // Read return: the cycle after a read command the SRAM presents its data.
  // The issued read command itself acts as the first pipeline stage, so reset
  // clearing mem_en also discards any read that is in flight.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= mem_en & ~mem_we;
    end
  end

  assign rd_data = mem_rdata;

`ifdef AXI_MEM_ARB_PERF_EN
  logic [31:0] perf_wr_q, perf_rd_q, perf_conf_q;

  // Saturating counters for grants and for cycles with both ports requesting.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      perf_wr_q   <= '0;
      perf_rd_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (grant_wr && (perf_wr_q != 32'hFFFF_FFFF)) begin
        perf_wr_q <= perf_wr_q + 32'd1;
      end
      if (grant_rd && (perf_rd_q != 32'hFFFF_FFFF)) begin
        perf_rd_q <= perf_rd_q + 32'd1;
      end
      if (wr_req && rd_req && (perf_conf_q != 32'hFFFF_FFFF)) begin
        perf_conf_q <= perf_conf_q + 32'd1;
      end
    end
  end

  assign perf_wr_cnt   = perf_wr_q;
  assign perf_rd_cnt   = perf_rd_q;
  assign perf_conf_cnt = perf_conf_q;
`else
  assign perf_wr_cnt   = '0;
  assign perf_rd_cnt   = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// tb_axi_mem_port_arbiter
// Directed scenarios followed by random traffic. A behavioural model tracks,
// in plain integers, which port holds the streak and for how long, plus a
// reference memory array and a queue of expected read returns. A separate
// SRAM model answers the DUT's memory commands.

module tb_axi_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MR = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   perf_wr_cnt, perf_rd_cnt, perf_conf_cnt;

  axi_mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .MAX_RUN(MR)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt), .perf_conf_cnt(perf_conf_cnt)
  );

  always #5 ACLK = ~ACLK;

  // SRAM model driven by the DUT's command outputs.
  logic [DW-1:0] sram [256];
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            streak_port = 0;  // 0 = write port, 1 = read port
  int            streak_len = 0;
  logic [DW-1:0] ref_mem [256];
  rd_exp_t       rq[$];
  logic          exp_en = 0, exp_we = 0, exp_all = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [SW-1:0] exp_wstrb = '0;
  int            cnt_wr = 0, cnt_rd = 0, cnt_conf = 0;
  int            wr_wait = 0, rd_wait = 0;
  logic          last_gw = 0, last_gr = 0;
  logic          seen_wg, seen_rg, seen_rv, seen_en, seen_we;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] perf_exp(input int cnt);
`ifdef AXI_MEM_ARB_PERF_EN
    return 32'(cnt);
`else
    return 32'd0 + 32'(cnt * 0);
`endif
  endfunction

  // One clock cycle with the inputs already driven: check at negedge, advance model at posedge.
  task automatic cycle_run();
    logic gw, gr, rst_now, owner_hit;
    @(negedge ACLK);
    rst_now = !ARESETn;
    gw = 1'b0;
    gr = 1'b0;
    if (!rst_now) begin
      if (wr_req && rd_req) begin
        // Streak holder keeps going until it has had MR grants in a row.
        if (streak_len < MR) begin gw = (streak_port == 0); gr = (streak_port == 1); end
        else                 begin gw = (streak_port == 1); gr = (streak_port == 0); end
      end else begin
        gw = wr_req;
        gr = rd_req;
      end
    end
    seen_wg = wr_gnt; seen_rg = rd_gnt; seen_rv = rd_valid; seen_rd = rd_data;
    seen_en = mem_en; seen_we = mem_we; seen_addr = mem_addr;
    check_val("wr_gnt", 32'(wr_gnt), 32'(gw));
    check_val("rd_gnt", 32'(rd_gnt), 32'(gr));
    check_val("mem_en", 32'(mem_en), 32'(exp_en));
    check_val("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_en || exp_all) begin
      check_val("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check_val("mem_wdata", mem_wdata, exp_wdata);
      check_val("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
    end
    if (!rst_now) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        check_val("rd_valid", 32'(rd_valid), 32'd1);
        check_val("rd_data", rd_data, rq[0].data);
        void'(rq.pop_front());
      end else begin
        check_val("rd_valid_idle", 32'(rd_valid), 32'd0);
      end
    end
    check_val("perf_wr", perf_wr_cnt, perf_exp(cnt_wr));
    check_val("perf_rd", perf_rd_cnt, perf_exp(cnt_rd));
    check_val("perf_conf", perf_conf_cnt, perf_exp(cnt_conf));

    @(posedge ACLK);
    if (rst_now) begin
      streak_port = 0; streak_len = 0;
      exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_all = 1;
      rq.delete();
      cnt_wr = 0; cnt_rd = 0; cnt_conf = 0;
      wr_wait = 0; rd_wait = 0;
    end else begin
      exp_all = 0;
      if (wr_req && rd_req) cnt_conf++;
      if (wr_req && !gw) wr_wait++;
      if (rd_req && !gr) rd_wait++;
      if (gw) begin check_val("wr_wait_bound", 32'(wr_wait <= MR), 32'd1); wr_wait = 0; end
      if (gr) begin check_val("rd_wait_bound", 32'(rd_wait <= MR), 32'd1); rd_wait = 0; end
      owner_hit = (gw && streak_port == 0) || (gr && streak_port == 1);
      if (!wr_req && !rd_req) streak_len = 0;
      else if (owner_hit) streak_len = (streak_len < MR) ? streak_len + 1 : MR;
      else begin streak_port = gw ? 0 : 1; streak_len = 1; end
      exp_en = gw | gr;
      exp_we = gw;
      if (gw) begin
        exp_addr = wr_addr; exp_wdata = wr_data; exp_wstrb = wr_strb;
        for (int b = 0; b < SW; b++)
          if (wr_strb[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        cnt_wr++;
      end else if (gr) begin
        exp_addr = rd_addr; exp_wstrb = '0;
        rq.push_back('{due: cyc + 2, data: ref_mem[rd_addr]});
        cnt_rd++;
      end else begin
        exp_wstrb = '0;
      end
    end
    last_gw = gw;
    last_gr = gr;
    cyc++;
    #1;
  endtask

  task automatic gen_wr(input int prob);
    if (!wr_req || last_gw) begin
      if (int'($urandom_range(0, 99)) < prob) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 7));
        wr_data = $urandom; wr_strb = SW'($urandom_range(0, 15));
      end else wr_req = 1'b0;
    end
  endtask

  task automatic gen_rd(input int prob);
    if (!rd_req || last_gr) begin
      if (int'($urandom_range(0, 99)) < prob) begin
        rd_req = 1'b1; rd_addr = AW'($urandom_range(0, 7));
      end else rd_req = 1'b0;
    end
  endtask

  // Reset cycle with both requests raised, to show grants are gated by reset.
  task automatic do_reset();
    ARESETn = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    cycle_run();
    ARESETn = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < n; i++) cycle_run();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    @(posedge ACLK); #1;
    do_reset();
    idle(1);

    // Write 0x10, then read it back.
    wr_req = 1; wr_addr = 8'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    cycle_run();
    check_val("dir_wr_gnt", 32'(seen_wg), 32'd1);
    wr_req = 0; rd_req = 1; rd_addr = 8'h10;
    cycle_run();
    check_val("dir_rd_gnt", 32'(seen_rg), 32'd1);
    check_val("dir_mem_en", 32'(seen_en), 32'd1);
    check_val("dir_mem_we", 32'(seen_we), 32'd1);
    check_val("dir_mem_addr", 32'(seen_addr), 32'h10);
    rd_req = 0;
    cycle_run();
    cycle_run();
    check_val("dir_rd_valid", 32'(seen_rv), 32'd1);
    check_val("dir_rd_data", seen_rd, 32'hDEADBEEF);

    // Write 0x20 then read 0x20 in the next cycle.
    wr_req = 1; wr_addr = 8'h20; wr_data = 32'h1234; wr_strb = 4'hF;
    cycle_run();
    wr_req = 0; rd_req = 1; rd_addr = 8'h20;
    cycle_run();
    rd_req = 0;
    cycle_run();
    cycle_run();
    check_val("raw_rd_valid", 32'(seen_rv), 32'd1);
    check_val("raw_rd_data", seen_rd, 32'h1234);
    idle(2);

    // Two reads in flight, then a one-cycle reset.
    rd_req = 1; rd_addr = 8'h01;
    cycle_run();
    rd_addr = 8'h02;
    cycle_run();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle_run();
      check_val("no_rv_after_reset", 32'(seen_rv), 32'd0);
    end

    // Both ports requesting continuously: WWWW RRRR WWWW ...
    for (int i = 0; i < 20; i++) begin
      gen_wr(100); gen_rd(100);
      cycle_run();
      check_val("pattern_wr", 32'(seen_wg), 32'(((i / 4) % 2) == 0));
      check_val("pattern_rd", 32'(seen_rg), 32'(((i / 4) % 2) == 1));
    end
    idle(3);

    // Counter scenario: 10 writes, 6 reads, 3 cycles with both requesting.
    do_reset();
    for (int i = 0; i < 3; i++) begin gen_wr(100); gen_rd(100); cycle_run(); end
    wr_req = 0;
    cycle_run();
    rd_req = 0;
    for (int i = 0; i < 7; i++) begin gen_wr(100); cycle_run(); end
    wr_req = 0;
    for (int i = 0; i < 5; i++) begin gen_rd(100); cycle_run(); end
    rd_req = 0;
    cycle_run();
    idle(1);
    check_val("perf_wr_total", perf_wr_cnt, perf_exp(10));
    check_val("perf_rd_total", perf_rd_cnt, perf_exp(6));
    check_val("perf_conf_total", perf_conf_cnt, perf_exp(3));

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      else begin
        gen_wr(55); gen_rd(55);
        cycle_run();
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
